priority_decoder: RTL and testbench

- Versat functional unit; the inverse of the team's priority encoder.
- Consumes an encoded lane index (0..2 = lane, 3 = "none") plus a data word, and routes the data to the selected one of three registered output lanes.
- Also publishes a one-hot select mask and a saturating match counter.
- Sits in the Versat datapath with a fixed registered latency of 1; typically fed directly by the encoder's index output.

---
 rtl/priority_decoder_pkg.sv | 16 +
 rtl/priority_decoder_lane.sv | 30 +++
 rtl/priority_decoder.sv | 71 +++++++
 tb/tb_priority_decoder.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/priority_decoder_pkg.sv
// Shared constants and lane-select encoding for the priority decoder.
// Lane indices match the priority encoder output; NONE_IDX means "no lane".
package priority_decoder_pkg;

  localparam int NUM_LANES = 3;
  localparam int NONE_IDX  = 3;
  localparam int MASK_W    = 4;

  typedef enum logic [1:0] {
    LANE0     = 2'd0,
    LANE1     = 2'd1,
    LANE2     = 2'd2,
    LANE_NONE = 2'(NONE_IDX)
  } lane_e;

endpackage

// File: rtl/priority_decoder_lane.sv
// One registered output lane: loads din when selected, otherwise holds or
// clears depending on the hold policy.
module priority_decoder_lane #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              sel_hit,
  input  logic              hold,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      dout <= '0;
    end else if (en) begin
      if (sel_hit) begin
        dout <= din;
      end else if (!hold) begin
        dout <= '0;
      end
    end
  end

endmodule

// File: rtl/priority_decoder.sv
// Decodes an encoded lane index into one of three registered data lanes,
// plus a one-hot select mask and a saturating match counter.
module priority_decoder
  import priority_decoder_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              running,
  input  logic              run,
  input  logic              hold,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  output logic [DATA_W-1:0] out0,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2,
  output logic [DATA_W-1:0] out3,
  output logic [DATA_W-1:0] out4
);

  lane_e               sel;
  logic                valid;
  logic [MASK_W-1:0]   mask_q;
  logic [DATA_W-1:0]   count_q;
  logic [DATA_W-1:0]   lane_q [NUM_LANES];

  // Full-width compare: any set upper bit must land on "none", not alias a lane.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sel = LANE_NONE;
    if (in0 < DATA_W'(NUM_LANES)) begin
      sel = lane_e'(in0[1:0]);
    end
  end

  assign valid = (sel != LANE_NONE);

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    priority_decoder_lane #(.DATA_W(DATA_W)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .clr     (run),
      .en      (running),
      .sel_hit (sel == lane_e'(2'(k))),
      .hold    (hold),
      .din     (in1),
      .dout    (lane_q[k])
    );
  end

  // LANE_NONE encodes as 3, so 1<<sel also yields the 4'b1000 "none" mask.
  always_ff @(posedge clk) begin
    if (rst || run) begin
      mask_q  <= '0;
      count_q <= '0;
    end else if (running) begin
      mask_q <= MASK_W'(1) << sel;
      if (valid && (count_q != '1)) begin
        count_q <= count_q + DATA_W'(1);
      end
    end
  end

  assign out0 = lane_q[0];
  assign out1 = lane_q[1];
  assign out2 = lane_q[2];
  assign out3 = DATA_W'(mask_q);
  assign out4 = count_q;

endmodule

// File: tb/tb_priority_decoder.sv
// Directed bench: table of single-cycle vectors on a 32-bit build plus a
// hand-written counter-saturation sequence on a 4-bit build.
module tb_priority_decoder;

  typedef struct {
    string       name;
    logic        rst;
    logic        run;
    logic        running;
    logic        hold;
    logic [31:0] in0;
    logic [31:0] in1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] e3;
    logic [31:0] e4;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, run, running, hold;
  logic [31:0] in0, in1;
  logic [31:0] out0, out1, out2, out3, out4;

  logic        s_rst, s_run, s_running, s_hold;
  logic [3:0]  s_in0, s_in1;
  logic [3:0]  s_out0, s_out1, s_out2, s_out3, s_out4;

  int compared = 0;
  int mismatched = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  priority_decoder #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .running(running), .run(run), .hold(hold),
    .in0(in0), .in1(in1),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3), .out4(out4)
  );

  priority_decoder #(.DATA_W(4)) dut4 (
    .clk(clk), .rst(s_rst), .running(s_running), .run(s_run), .hold(s_hold),
    .in0(s_in0), .in1(s_in1),
    .out0(s_out0), .out1(s_out1), .out2(s_out2), .out3(s_out3), .out4(s_out4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string name, input logic r, input logic rn, input logic rng,
                     input logic h, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                     input logic [31:0] e3, input logic [31:0] e4);
    vec_t v;
    v.name = name; v.rst = r; v.run = rn; v.running = rng; v.hold = h;
    v.in0 = a; v.in1 = d; v.e0 = e0; v.e1 = e1; v.e2 = e2; v.e3 = e3; v.e4 = e4;
    vq.push_back(v);
  endtask

  task automatic s_step(input logic rng, input logic h, input logic [3:0] a, input logic [3:0] d);
    s_rst = 1'b0; s_run = 1'b0; s_running = rng; s_hold = h; s_in0 = a; s_in1 = d;
    tick();
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; running = 1'b0; hold = 1'b0; in0 = '0; in1 = '0;
    s_rst = 1'b1; s_run = 1'b0; s_running = 1'b0; s_hold = 1'b0; s_in0 = '0; s_in1 = '0;

    //   name          rst run rng hold in0           in1          out0  out1  out2  out3 out4
    add("reset",       1, 0, 0, 0, 32'h1,        32'hAA,      0,    0,    0,    0, 0);
    add("run_discard", 0, 1, 1, 0, 32'h0,        32'h5,       0,    0,    0,    0, 0);
    add("h0_lane0",    0, 0, 1, 0, 32'h0,        32'h11,      'h11, 0,    0,    1, 1);
    add("h0_lane1",    0, 0, 1, 0, 32'h1,        32'h22,      0,    'h22, 0,    2, 2);
    add("h0_lane2",    0, 0, 1, 0, 32'h2,        32'h33,      0,    0,    'h33, 4, 3);
    add("rerun",       0, 1, 1, 1, 32'h1,        32'h9,       0,    0,    0,    0, 0);
    add("h1_lane0",    0, 0, 1, 1, 32'h0,        32'h11,      'h11, 0,    0,    1, 1);
    add("h1_lane1",    0, 0, 1, 1, 32'h1,        32'h22,      'h11, 'h22, 0,    2, 2);
    add("h1_lane2",    0, 0, 1, 1, 32'h2,        32'h33,      'h11, 'h22, 'h33, 4, 3);
    add("h1_none3",    0, 0, 1, 1, 32'h3,        32'h99,      'h11, 'h22, 'h33, 8, 3);
    add("h0_oor_100",  0, 0, 1, 0, 32'h100,      32'hFF,      0,    0,    0,    8, 3);
    add("h1_lane0b",   0, 0, 1, 1, 32'h0,        32'h44,      'h44, 0,    0,    1, 4);
    add("h1_oor_ff",   0, 0, 1, 1, 32'hFFFFFFFF, 32'h55,      'h44, 0,    0,    8, 4);
    add("h0_oor_ff",   0, 0, 1, 0, 32'hFFFFFFFF, 32'h66,      0,    0,    0,    8, 4);
    add("b2b_first",   0, 0, 1, 0, 32'h1,        32'h77,      0,    'h77, 0,    2, 5);
    add("b2b_second",  0, 0, 1, 0, 32'h1,        32'h78,      0,    'h78, 0,    2, 6);
    add("idle_a",      0, 0, 0, 0, 32'h0,        32'hDEAD,    0,    'h78, 0,    2, 6);
    add("idle_b",      0, 0, 0, 0, 32'h2,        32'hBEEF,    0,    'h78, 0,    2, 6);
    add("resume_h1",   0, 0, 1, 1, 32'h2,        32'h12,      0,    'h78, 'h12, 4, 7);
    add("run_idle",    0, 1, 0, 1, 32'h0,        32'h34,      0,    0,    0,    0, 0);
    add("pre_abort",   0, 0, 1, 1, 32'h0,        32'h5,       'h5,  0,    0,    1, 1);
    add("rst_abort",   1, 1, 1, 1, 32'h1,        32'h6,       0,    0,    0,    0, 0);

    foreach (vq[i]) begin
      rst = vq[i].rst; run = vq[i].run; running = vq[i].running; hold = vq[i].hold;
      in0 = vq[i].in0; in1 = vq[i].in1;
      tick();
      check({vq[i].name, ".out0"}, out0, vq[i].e0);
      check({vq[i].name, ".out1"}, out1, vq[i].e1);
      check({vq[i].name, ".out2"}, out2, vq[i].e2);
      check({vq[i].name, ".out3"}, out3, vq[i].e3);
      check({vq[i].name, ".out4"}, out4, vq[i].e4);
    end
    rst = 1'b0; running = 1'b0; run = 1'b0;

    // Counter saturation on the 4-bit build: 14 matches, then two more hit 15.
    tick();
    check("w4.reset_cnt", 32'(s_out4), 32'h0);
    for (int i = 0; i < 14; i++) s_step(1'b1, 1'b0, 4'(i % 3), 4'(i));
    check("w4.cnt14", 32'(s_out4), 32'd14);
    check("w4.lane1_last", 32'(s_out1), 32'd13);
    s_step(1'b1, 1'b0, 4'h2, 4'hA);
    check("w4.cnt15", 32'(s_out4), 32'd15);
    check("w4.mask4", 32'(s_out3), 32'h4);
    s_step(1'b1, 1'b0, 4'h0, 4'hB);
    check("w4.sat_hold", 32'(s_out4), 32'd15);
    check("w4.lane0", 32'(s_out0), 32'hB);
    s_step(1'b1, 1'b1, 4'hF, 4'hC);
    check("w4.none_cnt", 32'(s_out4), 32'd15);
    check("w4.none_mask", 32'(s_out3), 32'h8);
    check("w4.none_hold", 32'(s_out0), 32'hB);
    s_step(1'b1, 1'b1, 4'h1, 4'h3);
    check("w4.sat_again", 32'(s_out4), 32'd15);
    s_run = 1'b1; s_running = 1'b1; s_in0 = 4'h0; s_in1 = 4'h7;
    tick();
    check("w4.run_clr_cnt", 32'(s_out4), 32'd0);
    check("w4.run_clr_lane", 32'(s_out0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
